output_port_arbiter: RTL
========================

// Module: output_port_arbiter
// PURPOSE
//  Output stage of one router port, directly downstream of the per-input routing units.
//  Collects the per-direction requests those units raise for this port and arbitrates them round-robin.
//  Updates the hop field of each winning packet and holds it in a one-entry output register.
//  Drives the link (or local PE) with a valid/ready handshake.
// PARAMETERS
//  DATA_WIDTH  64  packet width; hop fields at [55:52] (x) and [51:48] (y)
//  NUM_IN      5   requesting inputs, index 0..4 = L,R,U,D,PE
//  HOP_SEL     0   hop update on grant: 0 none (PE port), 1 hop_x+1 (L/R port), 2 hop_y+1 (U/D port)
// PORTS
//  clk       in   1                  rising-edge clock
//  reset     in   1                  synchronous, active-high
//  reqIn     in   NUM_IN*5           5-bit request code per input; slice i nonzero = input i requests
//  dataIn    in   NUM_IN*DATA_WIDTH  packet from input i in slice i
//  gntOut    out  NUM_IN             one-hot; bit i high = input i's packet captured at this edge
//  outValid  out  1                  output register holds a packet
//  outData   out  DATA_WIDTH         held packet
//  outReady  in   1                  downstream accepts outData when outValid&outReady
//  pktCount  out  16                 packets delivered (outValid&outReady), wraps 0xFFFF->0
// BEHAVIOUR
//  Reset (sync, active-high, overrides all):
//   - outValid=0, outData=0, pktCount=0, rrPtr=0; gntOut=0 during reset.
//  State: EMPTY (outValid=0) / FULL (outValid=1).
//  canLoad = EMPTY | (FULL & outReady); same-cycle drain+refill required, no bubble.
//  req[i] = |reqIn[5i+4:5i].
//  Arbitration (combinational):
//   - Search order is rrPtr, rrPtr+1, ..., wrapping mod NUM_IN; first requester wins.
//   - gntOut[win]=1 only when canLoad and any req is set; gntOut is 0 otherwise.
//  On an edge with gntOut[win]=1:
//   - outData <= dataIn slice win, with hop field incremented per HOP_SEL.
//   - Hop increment is 4-bit modulo 16 (0xF -> 0x0); all other bits are unchanged.
//   - outValid <= 1; rrPtr <= (win+1) mod NUM_IN.
//  Drain without load: outValid <= 0; outData holds its last value.
//  No request and no drain: state and rrPtr hold.
//  Upstream holds reqIn/dataIn stable until it sees gntOut; gntOut is a one-cycle pulse per packet.
//  Latency: packet visible on outData the cycle after its gntOut pulse; max throughput 1 pkt/cycle.
//  FULL & !outReady: outData/outValid are held stable; gntOut=0; rrPtr unchanged.
//  pktCount increments on every edge where outValid&outReady (independent of load).
//  Reset mid-transfer: the held packet is dropped; gntOut in the reset cycle is 0, so no input loses a packet.
// TESTING
//  1. Reset, outReady=1, req from input 2 only, hop=0x00 (HOP_SEL=1)
//     -> gntOut=5'b00100; next cycle outValid=1, outData[55:52]=1.
//  2. All 5 inputs requesting continuously, outReady=1
//     -> grants 0,1,2,3,4,0 on consecutive cycles; pktCount=5 after 5 deliveries.
//  3. outReady=0 with output FULL, inputs 1,3 requesting
//     -> gntOut=0 and outData stable for 10 cycles; outReady=1 -> grant 1, then 3 next cycle.
//  4. HOP_SEL=2, hop_y=0xF
//     -> outData[51:48]=0x0; bits [55:52] and all other bits equal the input.
//  5. reset asserted while FULL with input 4 requesting
//     -> next cycle outValid=0, rrPtr=0, gntOut stays 0 during reset; input 4 is granted after reset.
//  6. pktCount preset near wrap (0xFFFF after 65535 deliveries)
//     -> next delivery gives pktCount=0.

Source files
------------

// File: rtl/output_port_arbiter.sv
// ---------------------------------------------------------------------------
// output_port_arbiter
//
// Output stage of one router port. It collects the requests raised by the
// per-input routing units for this port and arbitrates them round-robin. It
// bumps the hop field of the winning packet and holds that packet in a
// one-entry output register, which drives the link (or the local PE) through
// a valid/ready handshake.
//
// Parameters
//   DATA_WIDTH  packet width (hop_x at [55:52], hop_y at [51:48]; must be >= 56)
//   NUM_IN      number of requesting inputs (0..4 = L,R,U,D,PE)
//   HOP_SEL     hop update on grant: 0 none, 1 hop_x+1, 2 hop_y+1
//
// Ports
//   clk       in   rising-edge clock
//   reset     in   synchronous, active-high; overrides everything
//   reqIn     in   5-bit request code per input; a nonzero slice means a request
//   dataIn    in   packet from input i in slice i
//   gntOut    out  one-hot; bit i high = input i's packet is captured at this edge
//   outValid  out  output register holds a packet
//   outData   out  held packet
//   outReady  in   downstream accepts outData when outValid & outReady
//   pktCount  out  delivered packet count, wraps 0xFFFF -> 0
// ---------------------------------------------------------------------------
module output_port_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_IN     = 5,
    parameter int HOP_SEL    = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_IN*5-1:0]          reqIn,
    input  logic [NUM_IN*DATA_WIDTH-1:0] dataIn,
    output logic [NUM_IN-1:0]            gntOut,
    output logic                         outValid,
    output logic [DATA_WIDTH-1:0]        outData,
    input  logic                         outReady,
    output logic [15:0]                  pktCount
);

    localparam int PTR_W     = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
    localparam int HOP_X_LSB = 52;
    localparam int HOP_Y_LSB = 48;
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_IN - 1);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [PTR_W-1:0]        rr_q, rr_d;
    logic [15:0]             count_q, count_d;

    logic [NUM_IN-1:0]       req;
    logic [DATA_WIDTH-1:0]   in_data [NUM_IN];
    logic                    grant_any;
    logic [PTR_W-1:0]        grant_idx;
    logic [PTR_W-1:0]        cand;
    int                      cand_int;
    logic                    can_load;
    logic                    load;
    logic                    deliver;
    logic [DATA_WIDTH-1:0]   load_data;

    // Flatten the packed input buses into per-input requests and packets.
    always_comb begin
        for (int i = 0; i < NUM_IN; i++) begin
            req[i]     = |reqIn[i*5 +: 5];
            in_data[i] = dataIn[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Round-robin pick starting at rr_q. The walk runs from the farthest
    // offset back to offset 0, so the requester nearest rr_q is the last
    // assignment and therefore the winner.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first;
        // a path that leaves one unassigned would infer a latch.
        grant_idx = '0;
        cand      = '0;
        cand_int  = 0;
        for (int k = NUM_IN - 1; k >= 0; k--) begin
            cand_int = int'(rr_q) + k;
            if (cand_int >= NUM_IN) begin
                cand_int = cand_int - NUM_IN;
            end
            cand = PTR_W'(cand_int);
            if (req[cand]) begin
                grant_idx = cand;
            end
        end
        grant_any = |req;
    end

    // The register can take a new packet when empty, or when full and the
    // current packet leaves at this same edge (no bubble between packets).
    assign can_load = (state_q == ST_EMPTY) || outReady;
    assign load     = can_load && grant_any && !reset;
    assign deliver  = (state_q == ST_FULL) && outReady;

    always_comb begin
        gntOut = '0;
        if (load) begin
            gntOut[grant_idx] = 1'b1;
        end
    end

    // Hop update is a 4-bit modulo-16 increment; every other bit passes through.
    always_comb begin
        load_data = in_data[grant_idx];
        if (HOP_SEL == 1) begin
            load_data[HOP_X_LSB +: 4] = load_data[HOP_X_LSB +: 4] + 4'd1;
        end else if (HOP_SEL == 2) begin
            load_data[HOP_Y_LSB +: 4] = load_data[HOP_Y_LSB +: 4] + 4'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        rr_d    = rr_q;
        count_d = count_q + {15'd0, deliver};
        if (load) begin
            state_d = ST_FULL;
            data_d  = load_data;
            rr_d    = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
        end else if (deliver) begin
            // Drain without refill: outData keeps its last value.
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (reset) begin
            state_q <= ST_EMPTY;
            data_q  <= '0;
            rr_q    <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            rr_q    <= rr_d;
            count_q <= count_d;
        end
    end

    assign outValid = (state_q == ST_FULL);
    assign outData  = data_q;
    assign pktCount = count_q;

endmodule
